// File: rtl/hazard_scoreboard_unit_pkg.sv
// rtl/hazard_scoreboard_unit_pkg.sv - shared constants and types for the hazard/scoreboard unit
// Purpose: forwarding-select encodings and the MD scoreboard state type.
// Ports: none (package hazard_pkg).
package hazard_pkg;

  // Forwarding mux selects for the EX-stage operand muxes
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_scoreboard_unit_md_scoreboard.sv
// rtl/hazard_scoreboard_unit_md_scoreboard.sv - one-entry scoreboard for the multi-cycle mul/div unit
// Purpose: tracks a single outstanding MD op from EX entry to result-valid.
// Ports:
//   clk, rst_n     core clock, async active-low reset
//   mdStart        MD op enters EX this cycle
//   mdDestIn       destination of the entering MD op
//   mdBusy         an MD op is outstanding (includes the done cycle)
//   mdDone         MD result valid this cycle
//   mdDest         destination of the outstanding / retiring op
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mdStart,
  input  logic [RA_W-1:0] mdDestIn,
  output logic            mdBusy,
  output logic            mdDone,
  output logic [RA_W-1:0] mdDest
);

  localparam int CNT_W = $clog2(MD_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t       state;
  md_state_t       stateNext;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic [RA_W-1:0]  destNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      count  <= '0;
      mdDest <= '0;
    end else begin
      state  <= stateNext;
      count  <= countNext;
      mdDest <= destNext;
    end
  end

  // Countdown is loaded with MD_LAT-1 so the op is busy for MD_LAT-1 cycles
  // after EX entry, the last of which is the done cycle.
  always_comb begin
    stateNext = state;
    countNext = count;
    destNext  = mdDest;
    mdBusy    = 1'b0;
    mdDone    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (mdStart) begin
          stateNext = MD_BUSY;
          countNext = CNT_LOAD;
          destNext  = mdDestIn;
        end
      end
      MD_BUSY: begin
        mdBusy = 1'b1;
        if (count == CNT_ONE) begin
          mdDone = 1'b1;
          // Back-to-back: a new op may enter EX in the retiring cycle.
          if (mdStart) begin
            countNext = CNT_LOAD;
            destNext  = mdDestIn;
          end else begin
            stateNext = MD_IDLE;
            countNext = '0;
          end
        end else begin
          countNext = count - CNT_ONE;
        end
      end
      default: begin
        stateNext = MD_IDLE;
        countNext = '0;
      end
    endcase
  end

  // A second MD op can only reach EX while one is in flight if mdstall failed.
  mdStartWhileBusy: assert property (@(posedge clk) disable iff (!rst_n)
    !(mdStart && mdBusy && !mdDone));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - hazard unit: forwarding, load-use/branch/MD stalls
// Purpose: drives EX/ID forwarding selects and IF/ID/EX stall/flush for the
//   5-stage MIPS pipeline, with a one-entry scoreboard for the MD unit.
// Optional feature macro: STALL_PERF_EN (builds the stall-cycle counter;
//   otherwise stall_cycles is tied to zero).
// Ports:
//   clk, rst_n                      core clock, async active-low reset
//   RS_D, RT_D, UsesRT_D            ID sources, RT-read qualifier
//   BranchD, MdOp_D                 ID is branch / mult-div
//   RS_EX, RT_EX                    EX sources
//   WriteReg_E, RegWrite_E, MemToReg_E, MdStart_E, MdDest_E   EX control
//   WriteReg_M, RegWrite_M, MemToReg_M                        MEM control
//   WriteReg_W, RegWrite_W                                    WB control
//   ForwardAE/BE (2b), ForwardAD/BD forwarding selects
//   StallF, StallD, FlushE          pipeline hold / bubble
//   md_busy, md_done, md_dest       MD scoreboard status / retire port
//   stall_cycles                    stall performance counter
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] RS_D,
  input  logic [RA_W-1:0] RT_D,
  input  logic            UsesRT_D,
  input  logic            BranchD,
  input  logic            MdOp_D,
  input  logic [RA_W-1:0] RS_EX,
  input  logic [RA_W-1:0] RT_EX,
  input  logic [RA_W-1:0] WriteReg_E,
  input  logic            RegWrite_E,
  input  logic            MemToReg_E,
  input  logic            MdStart_E,
  input  logic [RA_W-1:0] MdDest_E,
  input  logic [RA_W-1:0] WriteReg_M,
  input  logic [RA_W-1:0] WriteReg_W,
  input  logic            RegWrite_M,
  input  logic            RegWrite_W,
  input  logic            MemToReg_M,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            ForwardAD,
  output logic            ForwardBD,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  output logic            md_busy,
  output logic            md_done,
  output logic [RA_W-1:0] md_dest,
  output logic [31:0]     stall_cycles
);

  // Register 0 is hardwired; a zero source never creates a dependency.
  logic rsExHitM, rsExHitW, rtExHitM, rtExHitW;
  logic rsDHitE, rtDHitE, rsDHitM, rtDHitM, rsDHitMd, rtDHitMd;
  logic lwStall, brStall, mdStall, stallAny;

  assign rsExHitM = (RS_EX != '0) && (RS_EX == WriteReg_M) && RegWrite_M;
  assign rsExHitW = (RS_EX != '0) && (RS_EX == WriteReg_W) && RegWrite_W;
  assign rtExHitM = (RT_EX != '0) && (RT_EX == WriteReg_M) && RegWrite_M;
  assign rtExHitW = (RT_EX != '0) && (RT_EX == WriteReg_W) && RegWrite_W;

  // MEM is the younger producer, so it wins a double match.
  always_comb begin
    ForwardAE = FWD_REGFILE;
    if (rsExHitM)      ForwardAE = FWD_MEM;
    else if (rsExHitW) ForwardAE = FWD_WB;
  end

  always_comb begin
    ForwardBE = FWD_REGFILE;
    if (rtExHitM)      ForwardBE = FWD_MEM;
    else if (rtExHitW) ForwardBE = FWD_WB;
  end

  // ID-stage source matches; RT only counts when the instruction reads it.
  assign rsDHitE  = (RS_D != '0) && (RS_D == WriteReg_E);
  assign rtDHitE  = UsesRT_D && (RT_D != '0) && (RT_D == WriteReg_E);
  assign rsDHitM  = (RS_D != '0) && (RS_D == WriteReg_M);
  assign rtDHitM  = UsesRT_D && (RT_D != '0) && (RT_D == WriteReg_M);
  assign rsDHitMd = (RS_D != '0) && (RS_D == md_dest);
  assign rtDHitMd = UsesRT_D && (RT_D != '0) && (RT_D == md_dest);

  // A load result in MEM is not yet available, so it is never forwarded to ID.
  assign ForwardAD = (RS_D != '0) && (RS_D == WriteReg_M) && RegWrite_M && !MemToReg_M;
  assign ForwardBD = (RT_D != '0) && (RT_D == WriteReg_M) && RegWrite_M && !MemToReg_M;

  assign lwStall = MemToReg_E && (rsDHitE || rtDHitE);
  assign brStall = BranchD && ((RegWrite_E && (rsDHitE || rtDHitE)) ||
                               (MemToReg_M && (rsDHitM || rtDHitM)));
  // RAW holds through the done cycle (regfile write lands at its end);
  // the structural term releases in the done cycle so a new MD op can follow.
  assign mdStall = (md_busy && (rsDHitMd || rtDHitMd)) ||
                   (md_busy && !md_done && MdOp_D);

  assign stallAny = lwStall | brStall | mdStall;
  assign StallF   = stallAny;
  assign StallD   = stallAny;
  assign FlushE   = stallAny;

  md_scoreboard #(
    .RA_W   (RA_W),
    .MD_LAT (MD_LAT)
  ) u_md_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .mdStart  (MdStart_E),
    .mdDestIn (MdDest_E),
    .mdBusy   (md_busy),
    .mdDone   (md_done),
    .mdDest   (md_dest)
  );

`ifdef STALL_PERF_EN
  logic [31:0] stallCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stallCount <= '0;
    else if (StallD) stallCount <= stallCount + 32'd1;
  end

  assign stall_cycles = stallCount;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  localparam int RA_W   = 5;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] RS_D, RT_D, RS_EX, RT_EX, WriteReg_E, MdDest_E, WriteReg_M, WriteReg_W;
  logic UsesRT_D, BranchD, MdOp_D, RegWrite_E, MemToReg_E, MdStart_E;
  logic RegWrite_M, RegWrite_W, MemToReg_M;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, StallF, StallD, FlushE, md_busy, md_done;
  logic [4:0] md_dest;
  logic [31:0] stall_cycles;

  hazard_scoreboard_unit #(.RA_W(RA_W), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RS_D(RS_D), .RT_D(RT_D), .UsesRT_D(UsesRT_D), .BranchD(BranchD), .MdOp_D(MdOp_D),
    .RS_EX(RS_EX), .RT_EX(RT_EX), .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E),
    .MemToReg_E(MemToReg_E), .MdStart_E(MdStart_E), .MdDest_E(MdDest_E),
    .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W), .RegWrite_M(RegWrite_M),
    .RegWrite_W(RegWrite_W), .MemToReg_M(MemToReg_M),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .md_busy(md_busy), .md_done(md_done), .md_dest(md_dest), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: MD op described by the cycle it retires in.
  int cyc = 0;
  bit mActive = 1'b0;
  int mDoneCyc = 0;
  logic [4:0] mDest = '0;
  logic [31:0] mStalls = '0;
  int lastDoneCyc = -100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mBusy();
    return mActive && (cyc <= mDoneCyc);
  endfunction

  function automatic bit mDone();
    return mActive && (cyc == mDoneCyc);
  endfunction

  function automatic bit hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 0) && (src == dst);
  endfunction

  function automatic bit readsReg(input logic [4:0] dst);
    return hit(RS_D, dst) || (UsesRT_D && hit(RT_D, dst));
  endfunction

  function automatic logic [1:0] fwdE(input logic [4:0] src);
    if (RegWrite_M && hit(src, WriteReg_M)) return 2'b10;
    if (RegWrite_W && hit(src, WriteReg_W)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    bit lw, br, md;
    lw = MemToReg_E && readsReg(WriteReg_E);
    br = BranchD && ((RegWrite_E && readsReg(WriteReg_E)) || (MemToReg_M && readsReg(WriteReg_M)));
    md = (mBusy() && readsReg(mDest)) || (mBusy() && !mDone() && MdOp_D);
    return lw || br || md;
  endfunction

  task automatic checkAll();
    bit s;
    s = expStall();
    check("ForwardAE", 32'(ForwardAE), 32'(fwdE(RS_EX)));
    check("ForwardBE", 32'(ForwardBE), 32'(fwdE(RT_EX)));
    check("ForwardAD", 32'(ForwardAD), 32'(RegWrite_M && !MemToReg_M && hit(RS_D, WriteReg_M)));
    check("ForwardBD", 32'(ForwardBD), 32'(RegWrite_M && !MemToReg_M && hit(RT_D, WriteReg_M)));
    check("StallF", 32'(StallF), 32'(s));
    check("StallD", 32'(StallD), 32'(s));
    check("FlushE", 32'(FlushE), 32'(s));
    check("md_busy", 32'(md_busy), 32'(mBusy()));
    check("md_done", 32'(md_done), 32'(mDone()));
    check("md_dest", 32'(md_dest), 32'(mDest));
`ifdef STALL_PERF_EN
    check("stall_cycles", stall_cycles, mStalls);
`else
    check("stall_cycles", stall_cycles, 32'd0);
`endif
  endtask

  // Advance one clock; model consumes the inputs present at the edge.
  task automatic tick();
    bit s;
    s = expStall();
    if (md_done === 1'b1) lastDoneCyc = cyc;
    @(posedge clk);
    if (rst_n) begin
      if (MdStart_E) begin
        mActive  = 1'b1;
        mDoneCyc = cyc + MD_LAT - 1;
        mDest    = MdDest_E;
      end
      if (s) mStalls = mStalls + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    #2;
    checkAll();
    tick();
  endtask

  task automatic clearIn();
    RS_D = 0; RT_D = 0; UsesRT_D = 0; BranchD = 0; MdOp_D = 0;
    RS_EX = 0; RT_EX = 0; WriteReg_E = 0; RegWrite_E = 0; MemToReg_E = 0;
    MdStart_E = 0; MdDest_E = 0; WriteReg_M = 0; WriteReg_W = 0;
    RegWrite_M = 0; RegWrite_W = 0; MemToReg_M = 0;
  endtask

  initial begin
    int firstDone;
    rst_n = 1'b0;
    clearIn();
    #3;
    checkAll();
    check("reset_md_busy", 32'(md_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    step();

    // 1: MEM wins over WB on double match
    RS_EX = 3; WriteReg_M = 3; RegWrite_M = 1; WriteReg_W = 3; RegWrite_W = 1;
    #2;
    check("t1_fwdAE_mem", 32'(ForwardAE), 32'h2);
    step();
    clearIn();

    // 2: load-use stall, and the register-0 case
    MemToReg_E = 1; WriteReg_E = 5; RS_D = 5;
    #2;
    check("t2_lwstall", 32'(FlushE), 32'd1);
    step();
    RS_D = 0; WriteReg_E = 0;
    #2;
    check("t2_reg0_nostall", 32'(StallD), 32'd0);
    step();
    clearIn();

    // 3: branch compare stalls on EX ALU producer, then on MEM load
    BranchD = 1; RS_D = 7; RegWrite_E = 1; WriteReg_E = 7;
    #2;
    check("t3_brstall_ex", 32'(StallD), 32'd1);
    step();
    RegWrite_E = 0; WriteReg_E = 0; MemToReg_M = 1; RegWrite_M = 1; WriteReg_M = 7;
    #2;
    check("t3_brstall_mem", 32'(StallD), 32'd1);
    check("t3_fwdAD_load", 32'(ForwardAD), 32'd0);
    step();
    clearIn();

    // 4: MD RAW stall through the done cycle
    MdStart_E = 1; MdDest_E = 9;
    step();
    MdStart_E = 0; RS_D = 9;
    for (int i = 1; i <= 4; i++) begin
      #2;
      check("t4_stallD", 32'(StallD), 32'(i <= 3));
      check("t4_md_done", 32'(md_done), 32'(i == 3));
      checkAll();
      tick();
    end
    clearIn();

    // 5: back-to-back MD ops, second enters EX the cycle after retire
    MdStart_E = 1; MdDest_E = 10;
    step();
    MdStart_E = 0; MdOp_D = 1;
    for (int i = 1; i <= 3; i++) begin
      #2;
      check("t5_struct_stall", 32'(StallD), 32'(i <= 2));
      if (i == 3) firstDone = cyc;
      checkAll();
      tick();
    end
    MdOp_D = 0; MdStart_E = 1; MdDest_E = 11;
    step();
    MdStart_E = 0;
    for (int i = 0; i < 4; i++) step();
    check("t5_done_gap", 32'(lastDoneCyc - firstDone), 32'd4);
    clearIn();

    // 6: reset mid-op aborts without a done pulse
    MdStart_E = 1; MdDest_E = 12; RS_D = 12;
    step();
    MdStart_E = 0;
    step();
    rst_n = 1'b0;
    mActive = 1'b0; mDest = '0; mStalls = '0;
    #1;
    check("t6_busy_async", 32'(md_busy), 32'd0);
    check("t6_done_async", 32'(md_done), 32'd0);
    check("t6_stall_cycles", stall_cycles, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("t6_no_done", 32'(md_done), 32'd0);
      checkAll();
      tick();
    end
    clearIn();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      RS_D = 5'($urandom_range(0, 7)); RT_D = 5'($urandom_range(0, 7));
      RS_EX = 5'($urandom_range(0, 7)); RT_EX = 5'($urandom_range(0, 7));
      WriteReg_E = 5'($urandom_range(0, 7)); WriteReg_M = 5'($urandom_range(0, 7));
      WriteReg_W = 5'($urandom_range(0, 7)); MdDest_E = 5'($urandom_range(0, 7));
      UsesRT_D = 1'($urandom); BranchD = 1'($urandom); MdOp_D = 1'($urandom);
      RegWrite_E = 1'($urandom); MemToReg_E = 1'($urandom);
      RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom); MemToReg_M = 1'($urandom);
      MdStart_E = (!(mBusy() && !mDone())) && ($urandom_range(0, 2) == 0);
      step();
    end
    clearIn();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
